// File: rtl/carpark_ctrl_multi_if.sv
// Lane-side signal bundle for carpark_ctrl_multi.
// The master drives sensors, ticket and payment; the slave drives bars, display and status.
interface carpark_ctrl_multi_if #(
    parameter int ID_W  = 3,
    parameter int FEE_W = 16
);
    logic             tick;
    logic             sin;
    logic             sout;
    logic [ID_W-1:0]  ticket_in;
    logic             pay;
    logic             bin;
    logic             bout;
    logic [ID_W-1:0]  ticket_out;
    logic             ticket_vld;
    logic [FEE_W-1:0] cost;
    logic             cost_vld;
    logic             err_ticket;
    logic             full;
    logic [ID_W:0]    free_cnt;

    modport master (
        output tick, sin, sout, ticket_in, pay,
        input  bin, bout, ticket_out, ticket_vld, cost, cost_vld,
        input  err_ticket, full, free_cnt
    );

    modport slave (
        input  tick, sin, sout, ticket_in, pay,
        output bin, bout, ticket_out, ticket_vld, cost, cost_vld,
        output err_ticket, full, free_cnt
    );
endinterface

// File: rtl/carpark_ctrl_multi.sv
// Multi-place car park: independent entry/exit lane FSMs, ticket table, fee calc.
// Define CARPARK_GRACE_EN to make stays up to GRACE_TICKS free of charge.
module carpark_ctrl_multi #(
    parameter int PMAX        = 5,
    parameter int ID_W        = 3,
    parameter int TW          = 16,
    parameter int BAR_CYCLES  = 5000,
    parameter int RATE        = 1,
    parameter int FEE_W       = 16,
    parameter int GRACE_TICKS = 10
) (
    input logic clk,
    input logic rst,
    carpark_ctrl_multi_if.slave cp
);
    localparam int BW = $clog2(BAR_CYCLES + 1);
    localparam int PW = TW + 32;
`ifdef CARPARK_GRACE_EN
    localparam int GRACE = GRACE_TICKS;
`else
    localparam int GRACE = 0;
`endif

    typedef enum logic [1:0] {E_IDLE, E_WAIT, E_OPEN} e_state_t;
    typedef enum logic [1:0] {X_IDLE, X_CALC, X_PAY, X_OPEN} x_state_t;

    e_state_t         e_st, e_nx;
    x_state_t         x_st, x_nx;
    logic [PMAX-1:0]  valid;
    logic [TW-1:0]    ts [PMAX];
    logic [TW-1:0]    now, ts_sel, dur, bill;
    logic [PW-1:0]    prod;
    logic [FEE_W-1:0] fee, cost_q;
    logic [ID_W:0]    free_q, free_nx;
    logic [ID_W-1:0]  free_id, id_q, tk_q;
    logic [BW-1:0]    e_cnt, x_cnt;
    logic             alloc, rel, id_ok, err_nx;
    logic             tk_vld_q, err_q, full_q;

    always_comb begin
        free_id = '0;
        for (int i = PMAX - 1; i >= 0; i--)
            if (!valid[i]) free_id = ID_W'(i);
    end

    always_comb begin
        id_ok  = 1'b0;
        ts_sel = '0;
        for (int i = 0; i < PMAX; i++) begin
            if (cp.ticket_in == ID_W'(i)) id_ok = valid[i];
            if (id_q == ID_W'(i)) ts_sel = ts[i];
        end
    end

    // Modular subtraction keeps the duration right across one counter wrap.
    always_comb begin
        dur  = now - ts_sel;
        bill = ({32'b0, dur} <= PW'(GRACE)) ? '0 : dur - TW'(GRACE);
        prod = PW'(bill) * PW'(RATE);
        fee  = (prod > PW'({FEE_W{1'b1}})) ? '1 : FEE_W'(prod);
    end

    always_comb begin
        e_nx  = e_st;
        alloc = 1'b0;
        unique case (e_st)
            E_IDLE:
                if (cp.sin) begin
                    if (free_q != '0) begin
                        alloc = 1'b1;
                        e_nx  = E_OPEN;
                    end else begin
                        e_nx = E_WAIT;
                    end
                end
            E_WAIT:
                if (!cp.sin) begin
                    e_nx = E_IDLE;
                end else if (free_q != '0) begin
                    alloc = 1'b1;
                    e_nx  = E_OPEN;
                end
            E_OPEN:
                if (e_cnt == BW'(BAR_CYCLES - 1)) e_nx = E_IDLE;
            default: e_nx = E_IDLE;
        endcase
    end

    always_comb begin
        x_nx   = x_st;
        rel    = 1'b0;
        err_nx = 1'b0;
        unique case (x_st)
            X_IDLE:
                if (cp.sout) begin
                    if (id_ok) x_nx = X_CALC;
                    else err_nx = 1'b1;
                end
            X_CALC: x_nx = X_PAY;
            X_PAY:
                if (cp.pay) begin
                    rel  = 1'b1;
                    x_nx = X_OPEN;
                end
            X_OPEN:
                if (x_cnt == BW'(BAR_CYCLES - 1)) x_nx = X_IDLE;
            default: x_nx = X_IDLE;
        endcase
    end

    assign free_nx = free_q - (ID_W+1)'(alloc) + (ID_W+1)'(rel);

    always_ff @(posedge clk) begin
        if (!rst) begin
            e_st <= E_IDLE;
            x_st <= X_IDLE;
        end else begin
            e_st <= e_nx;
            x_st <= x_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid    <= '0;
            now      <= '0;
            free_q   <= (ID_W+1)'(PMAX);
            full_q   <= 1'b0;
            e_cnt    <= '0;
            x_cnt    <= '0;
            tk_q     <= '0;
            tk_vld_q <= 1'b0;
            err_q    <= 1'b0;
            cost_q   <= '0;
            id_q     <= '0;
        end else begin
            now      <= now + TW'(cp.tick);
            free_q   <= free_nx;
            full_q   <= (free_nx == '0);
            tk_vld_q <= alloc;
            err_q    <= err_nx;
            e_cnt    <= (e_st == E_OPEN) ? e_cnt + 1'b1 : '0;
            x_cnt    <= (x_st == X_OPEN) ? x_cnt + 1'b1 : '0;
            if (alloc) tk_q <= free_id;
            if (x_st == X_IDLE && cp.sout) id_q <= cp.ticket_in;
            if (x_st == X_CALC) cost_q <= fee;
            for (int i = 0; i < PMAX; i++) begin
                if (alloc && free_id == ID_W'(i)) begin
                    valid[i] <= 1'b1;
                    ts[i]    <= now;
                end
                if (rel && id_q == ID_W'(i)) valid[i] <= 1'b0;
            end
        end
    end

    assign cp.bin        = (e_st == E_OPEN);
    assign cp.bout       = (x_st == X_OPEN);
    assign cp.cost_vld   = (x_st == X_PAY);
    assign cp.cost       = cost_q;
    assign cp.ticket_out = tk_q;
    assign cp.ticket_vld = tk_vld_q;
    assign cp.err_ticket = err_q;
    assign cp.full       = full_q;
    assign cp.free_cnt   = free_q;
endmodule
